// File: rtl/rv32_writeback_if.sv
// Writeback stage bus: issue handshake, load-data return, register-file write port and forwarding.
// The master side is the pipeline/memory driving the stage; the slave side is rv32_writeback.
interface rv32_writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rf_write_add;
    logic [31:0] rf_write_data;
    logic        fwd_valid;
    logic [31:0] retire_count;

    modport master (
        output in_valid, in_rd, in_is_load, in_funct3, in_addr_lo, in_result,
               mem_rvalid, mem_rdata,
        input  in_ready, rf_write_add, rf_write_data, fwd_valid, retire_count
    );

    modport slave (
        input  in_valid, in_rd, in_is_load, in_funct3, in_addr_lo, in_result,
               mem_rvalid, mem_rdata,
        output in_ready, rf_write_add, rf_write_data, fwd_valid, retire_count
    );
endinterface

// File: rtl/rv32_writeback.sv
// RV32I writeback stage: retires ALU results and aligned/extended loads onto the register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module rv32_writeback (
    input  logic             clk,
    input  logic             reset,
    rv32_writeback_if.slave  wb
);
    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t      state_q, state_d;
    logic [4:0]  ld_rd_q;
    logic [2:0]  ld_f3_q;
    logic [1:0]  ld_lo_q;
    logic        accept;
    logic        wr_en;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] ld_ext;

    assign accept = wb.in_valid && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept && wb.in_is_load) state_d = LOAD_WAIT;
            LOAD_WAIT: if (wb.mem_rvalid)           state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        wb.in_ready = 1'b0;
        wr_en       = 1'b0;
        wr_rd       = 5'd0;
        wr_data     = 32'd0;
        case (state_q)
            IDLE: begin
                wb.in_ready = 1'b1;
                if (accept && !wb.in_is_load) begin
                    wr_en   = 1'b1;
                    wr_rd   = wb.in_rd;
                    wr_data = wb.in_result;
                end
            end
            LOAD_WAIT: begin
                if (wb.mem_rvalid) begin
                    wr_en   = 1'b1;
                    wr_rd   = ld_rd_q;
                    wr_data = ld_ext;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_rd_q <= 5'd0;
            ld_f3_q <= 3'd0;
            ld_lo_q <= 2'd0;
        end else if (accept && wb.in_is_load) begin
            ld_rd_q <= wb.in_rd;
            ld_f3_q <= wb.in_funct3;
            ld_lo_q <= wb.in_addr_lo;
        end
    end

    // Little-endian lane select; halfword ignores addr bit 0 (misaligned halves are not split).
    always_comb begin
        case (ld_lo_q)
            2'd0:    byte_lane = wb.mem_rdata[7:0];
            2'd1:    byte_lane = wb.mem_rdata[15:8];
            2'd2:    byte_lane = wb.mem_rdata[23:16];
            default: byte_lane = wb.mem_rdata[31:24];
        endcase
        half_lane = ld_lo_q[1] ? wb.mem_rdata[31:16] : wb.mem_rdata[15:0];
        case (ld_f3_q)
            3'b000:  ld_ext = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  ld_ext = {{16{half_lane[15]}}, half_lane};
            3'b100:  ld_ext = {24'd0, byte_lane};
            3'b101:  ld_ext = {16'd0, half_lane};
            default: ld_ext = wb.mem_rdata;
        endcase
    end

    // The register file writes every cycle, so x0 and idle cycles must present a zero write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb.rf_write_add  <= 5'd0;
            wb.rf_write_data <= 32'd0;
            wb.fwd_valid     <= 1'b0;
        end else if (wr_en && (wr_rd != 5'd0)) begin
            wb.rf_write_add  <= wr_rd;
            wb.rf_write_data <= wr_data;
            wb.fwd_valid     <= 1'b1;
        end else begin
            wb.rf_write_add  <= 5'd0;
            wb.rf_write_data <= 32'd0;
            wb.fwd_valid     <= 1'b0;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)      retire_cnt_q <= 32'd0;
        else if (wr_en) retire_cnt_q <= retire_cnt_q + 32'd1;
    end

    assign wb.retire_count = retire_cnt_q;
`else
    assign wb.retire_count = 32'd0;
`endif

endmodule

// File: tb/tb_rv32_writeback.sv
// Directed self-checking bench for rv32_writeback: ALU writes, load extension, stalls, reset, counter.
module tb_rv32_writeback;
    logic clk;
    logic reset;
    int   tests;
    int   fails;
    logic [31:0] ret_exp;
    logic [31:0] rc_exp;

    rv32_writeback_if bus ();

    rv32_writeback dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_rd      = 5'd0;
        bus.in_is_load = 1'b0;
        bus.in_funct3  = 3'd0;
        bus.in_addr_lo = 2'd0;
        bus.in_result  = 32'd0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        ret_exp = 32'd0;
        tests++;
        if (bus.rf_write_add !== 5'd0 || bus.rf_write_data !== 32'd0 || bus.fwd_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got add=%0d data=%h fwd=%b, want 0/0/0",
                     bus.rf_write_add, bus.rf_write_data, bus.fwd_valid);
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", bus.in_ready);
        end
        tests++;
        if (bus.retire_count !== 32'd0) begin
            fails++;
            $display("FAIL reset_count: got %h want 0", bus.retire_count);
        end
    endtask

    task automatic test_alu();
        bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_rd = 5'd5; bus.in_result = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        ret_exp++;
        tests++;
        if (bus.rf_write_add !== 5'd5 || bus.rf_write_data !== 32'h1234_5678 || bus.fwd_valid !== 1'b1) begin
            fails++;
            $display("FAIL alu_write: got add=%0d data=%h fwd=%b, want 5/12345678/1",
                     bus.rf_write_add, bus.rf_write_data, bus.fwd_valid);
        end
        @(negedge clk);
        tests++;
        if (bus.rf_write_add !== 5'd0 || bus.rf_write_data !== 32'd0 || bus.fwd_valid !== 1'b0) begin
            fails++;
            $display("FAIL alu_idle_after: got add=%0d data=%h fwd=%b, want 0/0/0",
                     bus.rf_write_add, bus.rf_write_data, bus.fwd_valid);
        end
    endtask

    task automatic test_alu_back_to_back();
        logic [31:0] res [3];
        res[0] = 32'hAAAA_0001; res[1] = 32'hBBBB_0002; res[2] = 32'hCCCC_0003;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_is_load = 1'b0;
            bus.in_rd = 5'(10 + i); bus.in_result = res[i];
            @(negedge clk);
            ret_exp++;
            tests++;
            if (bus.rf_write_add !== 5'(10 + i) || bus.rf_write_data !== res[i] || bus.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_alu_%0d: got add=%0d data=%h rdy=%b, want %0d/%h/1",
                         i, bus.rf_write_add, bus.rf_write_data, bus.in_ready, 10 + i, res[i]);
            end
        end
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic do_load(input string name, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [1:0] lo, input logic [31:0] rdata, input logic [31:0] exp);
        bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_rd = rd;
        bus.in_funct3 = f3; bus.in_addr_lo = lo; bus.in_result = 32'hFFFF_FFFF;
        @(negedge clk);
        idle_inputs();
        tests++;
        if (bus.in_ready !== 1'b0 || bus.fwd_valid !== 1'b0 || bus.rf_write_add !== 5'd0) begin
            fails++;
            $display("FAIL %s_wait: got rdy=%b fwd=%b add=%0d, want 0/0/0",
                     name, bus.in_ready, bus.fwd_valid, bus.rf_write_add);
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = rdata;
        @(negedge clk);
        idle_inputs();
        ret_exp++;
        tests++;
        if (bus.rf_write_add !== rd || bus.rf_write_data !== exp || bus.fwd_valid !== (rd != 5'd0)
            || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: got add=%0d data=%h fwd=%b rdy=%b, want %0d/%h/%b/1",
                     name, bus.rf_write_add, bus.rf_write_data, bus.fwd_valid, bus.in_ready,
                     rd, exp, rd != 5'd0);
        end
        @(negedge clk);
    endtask

    task automatic test_load_ext();
        do_load("lb_a3",  5'd7, 3'b000, 2'd3, 32'h80FF_0011, 32'hFFFF_FF80);
        do_load("lbu_a3", 5'd7, 3'b100, 2'd3, 32'h80FF_0011, 32'h0000_0080);
        do_load("lh_a2",  5'd7, 3'b001, 2'd2, 32'h80FF_0011, 32'hFFFF_80FF);
        do_load("lhu_a0", 5'd7, 3'b101, 2'd0, 32'h80FF_0011, 32'h0000_0011);
        do_load("lb_a1",  5'd8, 3'b000, 2'd1, 32'h80FF_0011, 32'h0000_0000);
        do_load("lh_a3",  5'd8, 3'b001, 2'd3, 32'h80FF_0011, 32'hFFFF_80FF);
        do_load("lw",     5'd9, 3'b010, 2'd0, 32'h80FF_0011, 32'h80FF_0011);
        do_load("f3_111", 5'd9, 3'b111, 2'd2, 32'h1357_9BDF, 32'h1357_9BDF);
        do_load("ld_x0",  5'd0, 3'b010, 2'd0, 32'hCAFE_F00D, 32'h0000_0000);
    endtask

    task automatic test_rd_zero();
        bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_rd = 5'd0; bus.in_result = 32'hDEAD_BEEF;
        @(negedge clk);
        idle_inputs();
        ret_exp++;
        rc_exp = ret_exp;
`ifndef WB_RETIRE_CNT_EN
        rc_exp = 32'd0;
`endif
        tests++;
        if (bus.rf_write_add !== 5'd0 || bus.rf_write_data !== 32'd0 || bus.fwd_valid !== 1'b0) begin
            fails++;
            $display("FAIL rd0_write: got add=%0d data=%h fwd=%b, want 0/0/0",
                     bus.rf_write_add, bus.rf_write_data, bus.fwd_valid);
        end
        tests++;
        if (bus.retire_count !== rc_exp) begin
            fails++;
            $display("FAIL rd0_count: got %h want %h", bus.retire_count, rc_exp);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_hold();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_5555;
        @(negedge clk);
        idle_inputs();
        tests++;
        if (bus.fwd_valid !== 1'b0 || bus.rf_write_add !== 5'd0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rvalid_in_idle: got fwd=%b add=%0d rdy=%b, want 0/0/1",
                     bus.fwd_valid, bus.rf_write_add, bus.in_ready);
        end
        bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_rd = 5'd3;
        bus.in_funct3 = 3'b010; bus.in_addr_lo = 2'd0;
        @(negedge clk);
        bus.in_is_load = 1'b0; bus.in_rd = 5'd9; bus.in_result = 32'h0BAD_CAFE;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (bus.in_ready !== 1'b0 || bus.fwd_valid !== 1'b0) begin
                fails++;
                $display("FAIL stall_cycle_%0d: got rdy=%b fwd=%b, want 0/0", i, bus.in_ready, bus.fwd_valid);
            end
            @(negedge clk);
        end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0042;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_at_m: got rdy=%b want 0", bus.in_ready);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        ret_exp++;
        tests++;
        if (bus.rf_write_add !== 5'd3 || bus.rf_write_data !== 32'h0000_0042 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL stall_load_m1: got add=%0d data=%h rdy=%b, want 3/00000042/1",
                     bus.rf_write_add, bus.rf_write_data, bus.in_ready);
        end
        @(negedge clk);
        idle_inputs();
        ret_exp++;
        tests++;
        if (bus.rf_write_add !== 5'd9 || bus.rf_write_data !== 32'h0BAD_CAFE || bus.fwd_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_held_m2: got add=%0d data=%h fwd=%b, want 9/0badcafe/1",
                     bus.rf_write_add, bus.rf_write_data, bus.fwd_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_load();
        bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_rd = 5'd12; bus.in_funct3 = 3'b010;
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ret_exp = 32'd0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
        @(negedge clk);
        idle_inputs();
        tests++;
        if (bus.rf_write_add !== 5'd0 || bus.rf_write_data !== 32'd0 || bus.fwd_valid !== 1'b0
            || bus.retire_count !== 32'd0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_drops_load: got add=%0d data=%h fwd=%b cnt=%h rdy=%b, want 0/0/0/0/1",
                     bus.rf_write_add, bus.rf_write_data, bus.fwd_valid, bus.retire_count, bus.in_ready);
        end
    endtask

    task automatic test_retire_count();
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.in_is_load = 1'b0;
            bus.in_rd = 5'(i + 1); bus.in_result = 32'(i);
            @(negedge clk);
            ret_exp++;
        end
        idle_inputs();
        @(negedge clk);
        rc_exp = ret_exp;
`ifndef WB_RETIRE_CNT_EN
        rc_exp = 32'd0;
`endif
        tests++;
        if (bus.retire_count !== rc_exp) begin
            fails++;
            $display("FAIL count_after_10: got %h want %h", bus.retire_count, rc_exp);
        end
`ifdef WB_RETIRE_CNT_EN
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        release dut.retire_cnt_q;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_is_load = 1'b0; bus.in_rd = 5'd4; bus.in_result = 32'd1;
        @(negedge clk);
        idle_inputs();
        tests++;
        if (bus.retire_count !== 32'd0) begin
            fails++;
            $display("FAIL count_wrap: got %h want 0", bus.retire_count);
        end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ret_exp = 32'd0;
        rc_exp = 32'd0;
        test_reset();
        test_alu();
        test_alu_back_to_back();
        test_load_ext();
        test_rd_zero();
        test_stall_hold();
        test_reset_in_load();
        test_retire_count();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rv32_writeback.md
# rv32_writeback

Writeback stage of the RV32I core. Accepts completed instructions (ALU results or load requests) over a valid/ready handshake, waits for load data where needed, byte/half-aligns and sign/zero-extends loads, and drives the register file's write port. The register file has no write enable and writes `write_add`/`write_data` on every clock, so this block drives `rf_write_add = 0` and `rf_write_data = 0` whenever it is idle. It also exports the same values as a forwarding source for the decode stage.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  upstream presents an instruction.
- `in_ready`  out  1  stage can accept; high in IDLE only.
- `in_rd`  in  5  destination register.
- `in_is_load`  in  1  1 = load, data arrives on the mem port; 0 = `in_result` is final.
- `in_funct3`  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `in_addr_lo`  in  2  load address bits [1:0].
- `in_result`  in  32  ALU/jump result; ignored for loads.
- `mem_rvalid`  in  1  load data valid, single-cycle pulse.
- `mem_rdata`  in  32  raw little-endian load word.
- `rf_write_add`  out  5  to register file `write_add`; registered.
- `rf_write_data`  out  32  to register file `write_data`; registered.
- `fwd_valid`  out  1  registered; high when `rf_write_*` carries a real write with rd≠0.
- `retire_count`  out  32  retired-instruction counter; see Configuration.

## Operation
- FSM states:
  - IDLE: `in_ready = 1`.
  - LOAD_WAIT: `in_ready = 0`.
- A transfer occurs when `in_valid & in_ready`.
- **IDLE, transfer, `in_is_load = 0`:**
  - Next cycle: `rf_write_add = in_rd`, `rf_write_data = in_result`.
  - State stays IDLE.
- **IDLE, transfer, `in_is_load = 1`:**
  - Capture `in_rd`, `in_funct3` and `in_addr_lo`.
  - Go to LOAD_WAIT.
- **LOAD_WAIT, `mem_rvalid = 1`:**
  - Next cycle: `rf_write_add` = captured rd, `rf_write_data` = extended load data.
  - Go to IDLE.
- **Load extension:**
  - Byte lane = `mem_rdata[8*addr_lo +: 8]`.
  - Half lane = `mem_rdata[16*addr_lo[1] +: 16]`; `addr_lo[0]` is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW and funct3 011/110/111 write the full word.
- **rd = 0:** `rf_write_add = 0`, `rf_write_data = 0` and `fwd_valid = 0`, so x0 stays zero. The instruction still counts as retired.
- **No write produced in a cycle:** `rf_write_add = 0`, `rf_write_data = 0` and `fwd_valid = 0`. Outputs are never held over.
- **`mem_rvalid` in IDLE:** ignored.
- **`in_valid` in LOAD_WAIT:** not accepted. Upstream holds its instruction; it is accepted in the first IDLE cycle.

## Timing
- ALU result accepted at cycle N:
  - `rf_write_*` valid during cycle N+1.
  - Register file updated at the end of N+1; readable at N+2.
- Load: `mem_rvalid` at cycle M gives `rf_write_*` during M+1.
- At M+1 the state is already IDLE. A new instruction accepted at M+1 writes at M+2, so writes never collide.
- Minimum `mem_rvalid` latency is one cycle after load acceptance. The block does not time out.
- Throughput:
  - ALU-only: 1 instruction per cycle.
  - Load: occupies the stage from acceptance until the cycle its `mem_rvalid` arrives.
- **Reset:**
  - State IDLE; `rf_write_add = 0`, `rf_write_data = 0`, `fwd_valid = 0`, `retire_count = 0`.
  - `in_ready` is 1 in the first cycle after reset.
  - Reset during LOAD_WAIT drops the pending load. A late `mem_rvalid` then arrives in IDLE and is ignored.
- `reset` has priority over all other inputs in the same cycle.

## Configuration
- `WB_RETIRE_CNT_EN` defined:
  - `retire_count` is a 32-bit register, incremented by 1 in each cycle that follows a retirement, i.e. each cycle `rf_write_*` carries a completed instruction, including rd = 0.
  - Wraps from 0xFFFFFFFF to 0.
  - Cleared by reset.
- Not defined: `retire_count` is tied to 32'd0 and the counter logic is absent.

## Test plan
- Reset, then `in_valid` with rd=5, result=0x1234_5678, non-load at cycle N -> `rf_write_add = 5`, `rf_write_data = 0x12345678`, `fwd_valid = 1` at N+1; outputs back to 0/0/0 at N+2.
- LB with addr_lo=3, `mem_rdata = 0x80FF_0011`, rd=7 -> write 0xFFFFFF80. Same with LBU -> 0x00000080. LH with addr_lo=2 -> 0xFFFF80FF. LHU with addr_lo=0 -> 0x00000011.
- Non-load with rd=0, result=0xDEAD_BEEF -> `rf_write_add = 0`, `rf_write_data = 0`, `fwd_valid = 0`. With `WB_RETIRE_CNT_EN`, `retire_count` increments by 1.
- Load accepted, `in_valid` held high for 3 cycles before `mem_rvalid` -> `in_ready = 0` throughout LOAD_WAIT; the load writes at M+1; the held instruction is accepted at M+1 and writes at M+2.
- Reset asserted in LOAD_WAIT, then `mem_rvalid` the following cycle -> no write occurs, `rf_write_*` remain 0, `retire_count = 0`.
- With `WB_RETIRE_CNT_EN`, force the counter to 0xFFFFFFFF and retire one instruction -> `retire_count = 0`. Without the macro -> `retire_count` stays 0 after 10 retirements.
